// File: rtl/deflate_stream_packer.sv
// Captures the compressor's byte stream into a buffer, then replays it as a
// ready/valid frame: 4-byte little-endian length header followed by the payload.
module deflate_stream_packer #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_vld,
  input  logic [31:0] size_in,
  input  logic        size_vld,
  input  logic        core_done,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        overflow,
  output logic        size_mismatch
);

  typedef enum logic [1:0] {IDLE, CAPTURE, HEADER, PAYLOAD} state_t;

  localparam logic [ADDR_W:0]   ONE_P = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t            state_q;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, len_q;
  logic [31:0]       rx_count_q, rx_count_d, size_q, size_fin, len_ext;
  logic              size_seen_q;
  logic [1:0]        hdr_cnt_q;
  logic [7:0]        rd_data_q;
  logic [7:0]        m_data_q;
  logic              m_valid_q, m_last_q, busy_q, overflow_q, mismatch_q;
  logic              wr_en, xfer, load;
  logic [ADDR_W-1:0] rd_addr;

  function automatic logic [7:0] hdr_byte(input logic [31:0] len, input logic [1:0] idx);
    case (idx)
      2'd0:    hdr_byte = len[7:0];
      2'd1:    hdr_byte = len[15:8];
      2'd2:    hdr_byte = len[23:16];
      default: hdr_byte = len[31:24];
    endcase
  endfunction

  always_comb begin
    wr_en      = (state_q == CAPTURE) && in_vld && !wr_ptr_q[ADDR_W];
    wr_ptr_d   = wr_en ? wr_ptr_q + ONE_P : wr_ptr_q;
    rx_count_d = (in_vld && rx_count_q != '1) ? rx_count_q + 32'd1 : rx_count_q;
    size_fin   = size_vld ? size_in : size_q;
    len_ext    = {{(31-ADDR_W){1'b0}}, len_q};
    xfer       = m_valid_q && m_ready;
    // Advance the read address in the same cycle the output register takes
    // rd_data_q, so the next payload byte is ready one cycle later.
    load       = xfer && !m_last_q &&
                 ((state_q == HEADER && hdr_cnt_q == 2'd3) || state_q == PAYLOAD);
    rd_addr    = load ? rd_ptr_q[ADDR_W-1:0] + ONE_A : rd_ptr_q[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= in_data;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rx_count_q  <= '0;
      size_seen_q <= 1'b0;
      hdr_cnt_q   <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= CAPTURE;
            busy_q      <= 1'b1;
            wr_ptr_q    <= '0;
            rx_count_q  <= '0;
            overflow_q  <= 1'b0;
            mismatch_q  <= 1'b0;
            size_seen_q <= 1'b0;
          end
        end
        CAPTURE: begin
          wr_ptr_q   <= wr_ptr_d;
          rx_count_q <= rx_count_d;
          if (in_vld && wr_ptr_q[ADDR_W]) overflow_q <= 1'b1;
          if (size_vld) begin
            size_q      <= size_in;
            size_seen_q <= 1'b1;
          end
          if (core_done) begin
            state_q   <= HEADER;
            len_q     <= wr_ptr_d;
            rd_ptr_q  <= '0;
            hdr_cnt_q <= '0;
            m_valid_q <= 1'b1;
            m_data_q  <= wr_ptr_d[7:0];
            m_last_q  <= 1'b0;
            if (!(size_seen_q || size_vld) || size_fin != rx_count_d) mismatch_q <= 1'b1;
          end
        end
        HEADER: begin
          if (xfer) begin
            if (hdr_cnt_q == 2'd3) begin
              if (m_last_q) begin
                state_q   <= IDLE;
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                busy_q    <= 1'b0;
              end else begin
                state_q  <= PAYLOAD;
                m_data_q <= rd_data_q;
                rd_ptr_q <= rd_ptr_q + ONE_P;
                m_last_q <= (len_q == ONE_P);
              end
            end else begin
              hdr_cnt_q <= hdr_cnt_q + 2'd1;
              m_data_q  <= hdr_byte(len_ext, hdr_cnt_q + 2'd1);
              m_last_q  <= (hdr_cnt_q == 2'd2) && (len_q == '0);
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            if (m_last_q) begin
              state_q   <= IDLE;
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              m_data_q <= rd_data_q;
              rd_ptr_q <= rd_ptr_q + ONE_P;
              m_last_q <= (rd_ptr_q + ONE_P == len_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign m_last        = m_last_q;
  assign busy          = busy_q;
  assign overflow      = overflow_q;
  assign size_mismatch = mismatch_q;

endmodule

// File: tb/tb_deflate_stream_packer.sv
// Directed bench for deflate_stream_packer with a byte-level scoreboard on the
// output stream and stall-stability monitoring.
module tb_deflate_stream_packer;

  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 11;

  logic        clk = 1'b0;
  logic        rst, start, in_vld, size_vld, core_done, m_ready;
  logic [7:0]  in_data;
  logic [31:0] size_in;
  logic [7:0]  m_data;
  logic        m_valid, m_last, busy, overflow, size_mismatch;

  always #5 clk = ~clk;

  deflate_stream_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_vld(in_vld),
    .size_in(size_in), .size_vld(size_vld), .core_done(core_done),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .overflow(overflow), .size_mismatch(size_mismatch)
  );

  typedef struct packed {logic last; logic [7:0] data;} exp_t;
  exp_t       sb[$];
  logic [7:0] pay[$];
  int checks = 0, errors = 0, xfers = 0, ready_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: compare each transferred byte and verify holds during stalls.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        exp_t e;
        xfers++;
        check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_byte", {23'd0, m_last, m_data}, {23'd0, e.last, e.data});
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Drives one capture of pay[], pushing the expected frame first.
  // merge=1 puts size_vld and core_done on the cycle of the last byte.
  task automatic run_capture(input logic [31:0] sz, input bit szv, input bit merge);
    int n, l;
    logic [31:0] l32;
    exp_t e;
    n   = pay.size();
    l   = (n > DEPTH) ? DEPTH : n;
    l32 = l;
    for (int i = 0; i < 4; i++) begin
      e.data = l32[8*i +: 8];
      e.last = (i == 3) && (l == 0);
      sb.push_back(e);
    end
    for (int i = 0; i < l; i++) begin
      e.data = pay[i];
      e.last = (i == l - 1);
      sb.push_back(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (!merge && szv) begin
      size_in  = sz;
      size_vld = 1'b1;
      tick();
      size_vld = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      in_data = pay[i];
      in_vld  = 1'b1;
      if (merge && i == n - 1) begin
        core_done = 1'b1;
        size_in   = sz;
        size_vld  = szv;
      end
      tick();
      in_vld   = 1'b0;
      size_vld = 1'b0;
    end
    if (!merge) begin
      core_done = 1'b1;
      tick();
    end
    core_done = 1'b0;
    check("valid_after_done", {31'd0, m_valid}, 32'd1);
    check("busy_in_frame", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_frame(input int budget);
    for (int c = 0; c < budget && (sb.size() != 0 || busy); c++) tick();
    check("frame_done", {31'd0, (sb.size() == 0) && !busy}, 32'd1);
    check("idle_valid", {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; in_vld = 1'b0; size_vld = 1'b0; core_done = 1'b0;
    in_data = '0; size_in = '0; m_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_last", {31'd0, m_last}, 32'd0);
    check("rst_data", {24'd0, m_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_mismatch", {31'd0, size_mismatch}, 32'd0);

    // Basic frame, sink always ready
    ready_mode = 0;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_capture(32'd5, 1'b1, 1'b0);
    wait_frame(100);
    check("t1_mismatch", {31'd0, size_mismatch}, 32'd0);
    check("t1_overflow", {31'd0, overflow}, 32'd0);

    // Same frame, sink toggling
    ready_mode = 1;
    run_capture(32'd5, 1'b1, 1'b0);
    wait_frame(100);
    check("t2_mismatch", {31'd0, size_mismatch}, 32'd0);

    // Empty payload: header only, last on byte 3
    ready_mode = 0;
    pay.delete();
    run_capture(32'd0, 1'b1, 1'b0);
    wait_frame(100);
    check("t3_mismatch", {31'd0, size_mismatch}, 32'd0);

    // Overflow: DEPTH+3 bytes, header encodes DEPTH
    pay.delete();
    for (int i = 0; i < DEPTH + 3; i++) pay.push_back(8'(i) ^ 8'h5A);
    run_capture(DEPTH + 3, 1'b1, 1'b0);
    wait_frame(5000);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    check("t4_mismatch", {31'd0, size_mismatch}, 32'd0);

    // Size mismatch: 7 announced, 6 received; overflow cleared by start
    pay = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_capture(32'd7, 1'b1, 1'b0);
    wait_frame(100);
    check("t5_mismatch", {31'd0, size_mismatch}, 32'd1);
    check("t5_overflow", {31'd0, overflow}, 32'd0);

    // Last byte, size and core_done together; random sink
    ready_mode = 2;
    pay = '{8'hC3, 8'h3C, 8'h7E};
    run_capture(32'd3, 1'b1, 1'b1);
    wait_frame(200);
    check("t7_mismatch", {31'd0, size_mismatch}, 32'd0);

    // No size ever latched
    ready_mode = 0;
    pay = '{8'h01, 8'h02};
    run_capture(32'd2, 1'b0, 1'b0);
    wait_frame(100);
    check("t8_mismatch", {31'd0, size_mismatch}, 32'd1);

    // Reset mid-payload, then a clean frame
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'(i * 7 + 3));
    base = xfers;
    run_capture(32'd20, 1'b1, 1'b0);
    for (int c = 0; c < 200 && xfers < base + 7; c++) tick();
    check("t6_in_payload", {31'd0, xfers >= base + 7}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("t6_valid", {31'd0, m_valid}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_last", {31'd0, m_last}, 32'd0);
    tick();
    check("t6_stays_idle", {31'd0, m_valid | busy}, 32'd0);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_capture(32'd4, 1'b1, 1'b0);
    wait_frame(100);
    check("t6_mismatch", {31'd0, size_mismatch}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
